blake_host_ctrl: RTL and testbench

BLAKE_HOST_CTRL -- requirements
Module: blake_host_ctrl

---
 rtl/blake_host_ctrl.sv | 169 ++++++++++++++++
 tb/tb_blake_host_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/blake_host_ctrl.sv
// Host-side sequencer for a BLAKE-style hash core: streams message words into
// the core one at a time, then pulls digest words back out through a valid/ready port.
module blake_host_ctrl #(
  parameter int BLOCK_WORDS = 32,
  parameter int DIG_WORDS   = 16,
  parameter int TIMEOUT     = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        msg_valid,
  input  logic [15:0] msg_data,
  input  logic        msg_last,
  output logic        msg_ready,
  output logic        dig_valid,
  output logic [15:0] dig_data,
  input  logic        dig_ready,
  output logic        core_init,
  output logic        core_load,
  output logic        core_fetch,
  output logic [15:0] core_idata,
  input  logic        core_ack,
  input  logic [15:0] core_odata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [15:0] block_cnt
);

  localparam int WCW = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
  localparam int DCW = $clog2(DIG_WORDS + 1);
  localparam logic [WCW-1:0] LAST_POS = WCW'(BLOCK_WORDS - 1);
  localparam logic [DCW-1:0] DIG_LAST = DCW'(DIG_WORDS);
  localparam logic [7:0]     WAIT_MAX = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_LOAD, S_FETCH, S_ERR} state_t;

  state_t           r_state, w_next_state;
  logic             r_hold_full, r_hold_last;
  logic [15:0]      r_hold_data;
  logic [WCW-1:0]   r_word_cnt;
  logic [15:0]      r_block_cnt;
  logic [DCW-1:0]   r_fetch_cnt;
  logic             r_dig_valid;
  logic [15:0]      r_dig_data;
  logic [7:0]       r_wait_cnt;
  logic [1:0]       r_err_code;
  logic             r_done;

  logic w_core_init, w_core_load, w_core_fetch, w_msg_ready;
  logic w_capture, w_last_err, w_load_done, w_fetch_done, w_dig_take, w_job_done, w_timeout;

  // Strobes are decoded from registered state only, so they are mutually exclusive by construction.
  assign w_core_init  = (r_state == S_INIT);
  assign w_core_load  = (r_state == S_LOAD) && r_hold_full;
  assign w_core_fetch = (r_state == S_FETCH) && !r_dig_valid && (r_fetch_cnt != DIG_LAST);
  assign w_msg_ready  = (r_state == S_LOAD) && !r_hold_full;
  assign w_capture    = msg_valid && w_msg_ready;
  assign w_last_err   = w_capture && msg_last && (r_word_cnt != LAST_POS);
  assign w_load_done  = w_core_load && core_ack;
  assign w_fetch_done = w_core_fetch && core_ack;
  assign w_dig_take   = r_dig_valid && dig_ready;
  assign w_job_done   = (r_state == S_FETCH) && w_dig_take && (r_fetch_cnt == DIG_LAST);
  assign w_timeout    = (w_core_load || w_core_fetch) && !core_ack && (r_wait_cnt == WAIT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_INIT;
      S_INIT:  w_next_state = S_LOAD;
      S_LOAD: begin
        if (w_last_err || w_timeout)         w_next_state = S_ERR;
        else if (w_load_done && r_hold_last) w_next_state = S_FETCH;
      end
      S_FETCH: begin
        if (w_timeout)       w_next_state = S_ERR;
        else if (w_job_done) w_next_state = S_IDLE;
      end
      S_ERR:   w_next_state = S_ERR;
      default: w_next_state = S_IDLE;
    endcase
    if (abort) w_next_state = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_full <= 1'b0;
      r_hold_last <= 1'b0;
      r_hold_data <= '0;
      r_word_cnt  <= '0;
      r_block_cnt <= '0;
      r_fetch_cnt <= '0;
      r_dig_valid <= 1'b0;
      r_dig_data  <= '0;
      r_wait_cnt  <= '0;
      r_err_code  <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= !abort && w_job_done;
      if (abort) begin
        r_hold_full <= 1'b0;
        r_hold_last <= 1'b0;
        r_hold_data <= '0;
        r_word_cnt  <= '0;
        r_block_cnt <= '0;
        r_fetch_cnt <= '0;
        r_dig_valid <= 1'b0;
        r_dig_data  <= '0;
        r_wait_cnt  <= '0;
        r_err_code  <= '0;
      end else begin
        if ((r_state == S_IDLE) && start) begin
          r_hold_full <= 1'b0;
          r_word_cnt  <= '0;
          r_block_cnt <= '0;
          r_fetch_cnt <= '0;
          r_dig_valid <= 1'b0;
          r_wait_cnt  <= '0;
          r_err_code  <= '0;
        end
        // A premature last word is dropped rather than forwarded to the core.
        if (w_capture && !w_last_err) begin
          r_hold_full <= 1'b1;
          r_hold_data <= msg_data;
          r_hold_last <= msg_last;
        end
        if (w_last_err) r_err_code <= 2'b01;
        if (w_load_done) begin
          r_hold_full <= 1'b0;
          if (r_word_cnt == LAST_POS) begin
            r_word_cnt  <= '0;
            r_block_cnt <= r_block_cnt + 16'd1;
          end else begin
            r_word_cnt  <= r_word_cnt + 1'b1;
          end
        end
        if (w_fetch_done) begin
          r_dig_data  <= core_odata;
          r_dig_valid <= 1'b1;
          r_fetch_cnt <= r_fetch_cnt + 1'b1;
        end
        if (w_dig_take) r_dig_valid <= 1'b0;
        if (w_core_load || w_core_fetch) r_wait_cnt <= core_ack ? 8'd0 : r_wait_cnt + 8'd1;
        if (w_timeout) r_err_code <= 2'b10;
      end
    end
  end

  assign core_init  = w_core_init;
  assign core_load  = w_core_load;
  assign core_fetch = w_core_fetch;
  assign core_idata = w_core_load ? r_hold_data : 16'd0;
  assign msg_ready  = w_msg_ready;
  assign dig_valid  = r_dig_valid;
  assign dig_data   = r_dig_data;
  assign busy       = (r_state != S_IDLE);
  assign done       = r_done;
  assign err        = (r_state == S_ERR);
  assign err_code   = r_err_code;
  assign block_cnt  = r_block_cnt;

endmodule

// File: tb/tb_blake_host_ctrl.sv
// Directed bench for blake_host_ctrl: a cycle-stepped core/host model drives
// whole jobs and checks load order, digest order, counters and error paths.
module tb_blake_host_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort;
  logic        msg_valid, msg_last, msg_ready;
  logic [15:0] msg_data;
  logic        dig_valid, dig_ready;
  logic [15:0] dig_data;
  logic        core_init, core_load, core_fetch, core_ack;
  logic [15:0] core_idata, core_odata;
  logic        busy, done, err;
  logic [1:0]  err_code;
  logic [15:0] block_cnt;

  int vectors = 0;
  int miscompares = 0;
  int initCount, loadsSeen, digCount, doneCount, loadHigh, hitBudget;

  blake_host_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .msg_valid(msg_valid), .msg_data(msg_data), .msg_last(msg_last), .msg_ready(msg_ready),
    .dig_valid(dig_valid), .dig_data(dig_data), .dig_ready(dig_ready),
    .core_init(core_init), .core_load(core_load), .core_fetch(core_fetch),
    .core_idata(core_idata), .core_ack(core_ack), .core_odata(core_odata),
    .busy(busy), .done(done), .err(err), .err_code(err_code), .block_cnt(block_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Steps one cycle at a time, acting as both message source, hash core and digest sink.
  task automatic runJob(input int nWords, input int lastAt, input logic ackOn,
                        input logic stallAt3, input int budget);
    int wordIdx = 0;
    int fetchCount = 0;
    int stallCnt = 0;
    int cyc;
    initCount = 0; loadsSeen = 0; digCount = 0; doneCount = 0; loadHigh = 0; hitBudget = 0;
    core_ack  = ackOn;
    dig_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (cyc = 0; cyc < budget; cyc++) begin
      core_odata = 16'hA000 + 16'(fetchCount);
      msg_valid  = (wordIdx < nWords);
      msg_data   = 16'(wordIdx);
      msg_last   = (wordIdx == lastAt);
      check("strobe_excl", 64'(int'(core_init) + int'(core_load) + int'(core_fetch) <= 1), 64'd1);
      if (done) doneCount++;
      if (err || done) break;
      if (core_init) initCount++;
      if (core_load) begin
        loadHigh++;
        if (core_ack) begin
          check("load_data", 64'(core_idata), 64'(loadsSeen));
          loadsSeen++;
        end
      end
      if (core_fetch && core_ack) fetchCount++;
      dig_ready = 1'b1;
      if (dig_valid) begin
        if (stallAt3 && digCount == 3 && stallCnt < 10) begin
          dig_ready = 1'b0;
          check("stall_data", 64'(dig_data), 64'h0000_0000_0000_A003);
          check("stall_nofetch", 64'(core_fetch), 64'd0);
          stallCnt++;
        end else begin
          check("dig_data", 64'(dig_data), 64'(16'hA000 + 16'(digCount)));
          digCount++;
        end
      end
      if (msg_valid && msg_ready) wordIdx++;
      tick();
    end
    if (cyc == budget) hitBudget = 1;
    check("within_budget", 64'(hitBudget), 64'd0);
    msg_valid = 1'b0;
    msg_last  = 1'b0;
  endtask

  // Linear directed sequence: reset, clean jobs, backpressure, both error paths, mid-job reset.
  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    msg_valid = 1'b0; msg_data = 16'd0; msg_last = 1'b0;
    dig_ready = 1'b0; core_ack = 1'b0; core_odata = 16'd0;
    tick();
    tick();
    check("reset_outputs", 64'({core_init, core_load, core_fetch, core_idata, msg_ready, dig_valid,
          dig_data, done, busy, err, err_code, block_cnt}), 64'd0);
    rst_n = 1'b1;
    tick();

    runJob(32, 31, 1'b1, 1'b0, 300);
    check("A_init", 64'(initCount), 64'd1);
    check("A_loads", 64'(loadsSeen), 64'd32);
    check("A_digs", 64'(digCount), 64'd16);
    check("A_done", 64'(doneCount), 64'd1);
    check("A_block_cnt", 64'(block_cnt), 64'd1);
    check("A_idle", 64'(busy), 64'd0);
    tick();
    check("A_done_pulse", 64'(done), 64'd0);

    runJob(64, 63, 1'b1, 1'b0, 400);
    check("B_init", 64'(initCount), 64'd1);
    check("B_loads", 64'(loadsSeen), 64'd64);
    check("B_block_cnt", 64'(block_cnt), 64'd2);
    check("B_digs", 64'(digCount), 64'd16);
    check("B_done", 64'(doneCount), 64'd1);
    tick();

    runJob(32, 31, 1'b1, 1'b1, 300);
    check("C_digs", 64'(digCount), 64'd16);
    check("C_done", 64'(doneCount), 64'd1);
    tick();

    runJob(6, 5, 1'b1, 1'b0, 200);
    check("D_err", 64'(err), 64'd1);
    check("D_err_code", 64'(err_code), 64'd1);
    check("D_loads", 64'(loadsSeen), 64'd5);
    check("D_busy", 64'(busy), 64'd1);
    check("D_quiet", 64'({core_load, core_fetch, msg_ready, dig_valid}), 64'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("D_abort", 64'({busy, err, err_code, block_cnt}), 64'd0);

    runJob(1, 99, 1'b0, 1'b0, 400);
    check("E_load_cycles", 64'(loadHigh), 64'd255);
    check("E_err_code", 64'(err_code), 64'd2);
    check("E_err", 64'(err), 64'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("E_abort", 64'({busy, err, err_code}), 64'd0);
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    check("abort_beats_start", 64'(busy), 64'd0);

    core_ack = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    msg_valid = 1'b1;
    msg_data  = 16'h0055;
    for (int i = 0; i < 10 && !core_load; i++) tick();
    check("F_hold_full", 64'(core_load), 64'd1);
    rst_n = 1'b0;
    #1;
    check("F_async_reset", 64'({core_init, core_load, core_fetch, core_idata, msg_ready, dig_valid,
          dig_data, done, busy, err, err_code, block_cnt}), 64'd0);
    msg_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    runJob(32, 31, 1'b1, 1'b0, 300);
    check("F_init", 64'(initCount), 64'd1);
    check("F_loads", 64'(loadsSeen), 64'd32);
    check("F_digs", 64'(digCount), 64'd16);
    check("F_block_cnt", 64'(block_cnt), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
